// File: rtl/riscv_mpsoc_pkg.sv
// Shared AHB and BIU encodings for the MPSoC-RISCV bus interface blocks,
// plus the queued-request record used by the BIU-to-AHB bridge.
package riscv_mpsoc_pkg;
    localparam int MAX_PLEN = 64;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HWORD = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic [3:0] HPROT_OPCODE         = 4'b0000;
    localparam logic [3:0] HPROT_DATA           = 4'b0001;
    localparam logic [3:0] HPROT_USER           = 4'b0000;
    localparam logic [3:0] HPROT_PRIVILEGED     = 4'b0010;
    localparam logic [3:0] HPROT_NON_BUFFERABLE = 4'b0000;
    localparam logic [3:0] HPROT_BUFFERABLE     = 4'b0100;
    localparam logic [3:0] HPROT_NON_CACHEABLE  = 4'b0000;
    localparam logic [3:0] HPROT_CACHEABLE      = 4'b1000;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // BIU burst types share the AHB HBURST encoding
    localparam logic [2:0] BIU_SINGLE = 3'd0;
    localparam logic [2:0] BIU_INCR   = 3'd1;
    localparam logic [2:0] BIU_WRAP4  = 3'd2;
    localparam logic [2:0] BIU_INCR4  = 3'd3;
    localparam logic [2:0] BIU_WRAP8  = 3'd4;
    localparam logic [2:0] BIU_INCR8  = 3'd5;
    localparam logic [2:0] BIU_WRAP16 = 3'd6;
    localparam logic [2:0] BIU_INCR16 = 3'd7;

    localparam logic [2:0] PROT_INSTRUCTION = 3'b000;
    localparam logic [2:0] PROT_DATA        = 3'b001;
    localparam logic [2:0] PROT_USER        = 3'b000;
    localparam logic [2:0] PROT_PRIVILEGED  = 3'b010;
    localparam logic [2:0] PROT_NONCACHEABLE = 3'b000;
    localparam logic [2:0] PROT_CACHEABLE   = 3'b100;

    typedef struct packed {
        logic [MAX_PLEN-1:0] adr;
        logic [2:0]          size;
        logic [2:0]          btype;
        logic [2:0]          prot;
        logic                lock;
        logic                we;
    } biu_req_t;

    function automatic logic [3:0] biu_prot2hprot(input logic [2:0] prot);
        logic [3:0] hp;
        hp = HPROT_NON_BUFFERABLE;
        hp = hp | ((prot & PROT_DATA)       != 3'b000 ? HPROT_DATA       : HPROT_OPCODE);
        hp = hp | ((prot & PROT_PRIVILEGED) != 3'b000 ? HPROT_PRIVILEGED : HPROT_USER);
        hp = hp | ((prot & PROT_CACHEABLE)  != 3'b000 ? HPROT_CACHEABLE  : HPROT_NON_CACHEABLE);
        return hp;
    endfunction
endpackage

// File: rtl/riscv_biu_reqfifo.sv
// Synchronous request FIFO of biu_req_t; push while full is accepted only
// together with a pop in the same cycle.
module riscv_biu_reqfifo
    import riscv_mpsoc_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     HCLK,
    input  logic     HRESETn,
    input  logic     push,
    input  biu_req_t d,
    input  logic     pop,
    output biu_req_t q,
    output logic     full,
    output logic     empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    biu_req_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push, do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign q       = mem[rd_ptr];

    always_ff @(posedge HCLK) begin
        if (do_push) mem[wr_ptr] <= d;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/riscv_biu2ahb_q.sv
// Queued BIU-to-AHB-Lite master: back-to-back transfers, 1 KB split of
// incrementing bursts, clean abort on ERROR response.
module riscv_biu2ahb_q
    import riscv_mpsoc_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int PLEN   = 64,
    parameter int QDEPTH = 2
) (
    input  logic            HRESETn,
    input  logic            HCLK,
    output logic            HSEL,
    output logic [PLEN-1:0] HADDR,
    output logic [XLEN-1:0] HWDATA,
    input  logic [XLEN-1:0] HRDATA,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [2:0]      HBURST,
    output logic [3:0]      HPROT,
    output logic [1:0]      HTRANS,
    output logic            HMASTLOCK,
    input  logic            HREADY,
    input  logic            HRESP,
    input  logic            biu_stb_i,
    output logic            biu_stb_ack_o,
    output logic            biu_d_ack_o,
    input  logic [PLEN-1:0] biu_adri_i,
    output logic [PLEN-1:0] biu_adro_o,
    input  logic [2:0]      biu_size_i,
    input  logic [2:0]      biu_type_i,
    input  logic [2:0]      biu_prot_i,
    input  logic            biu_lock_i,
    input  logic            biu_we_i,
    input  logic [XLEN-1:0] biu_d_i,
    output logic [XLEN-1:0] biu_q_o,
    output logic            biu_ack_o,
    output logic            biu_err_o
);
    localparam int BYTES = XLEN / 8;
    localparam int ALSB  = $clog2(BYTES);

    typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_ERR} state_t;

    state_t          state;
    logic [3:0]      beat_cnt;
    logic            data_vld, addr_vld;
    logic [XLEN-1:0] d_dly;
    logic [PLEN-1:0] nxt;
    logic            split;
    logic            full, empty, have_req, take, fifo_pop, fifo_push;
    biu_req_t        req_in, fifo_q, head;

    function automatic logic [PLEN-1:0] next_addr(input logic [PLEN-1:0] a, input logic [2:0] burst);
        logic [PLEN-1:0] inc, mask;
        inc = {a[PLEN-1:ALSB] + 1'b1, {ALSB{1'b0}}};
        case (burst)
            HBURST_WRAP4:  mask = PLEN'(4*BYTES - 1);
            HBURST_WRAP8:  mask = PLEN'(8*BYTES - 1);
            HBURST_WRAP16: mask = PLEN'(16*BYTES - 1);
            default:       mask = '1;
        endcase
        return (a & ~mask) | (inc & mask);
    endfunction

    function automatic logic [3:0] burst_beats(input logic [2:0] btype);
        case (btype)
            BIU_INCR4,  BIU_WRAP4:  return 4'd3;
            BIU_INCR8,  BIU_WRAP8:  return 4'd7;
            BIU_INCR16, BIU_WRAP16: return 4'd15;
            default:                return 4'd0;
        endcase
    endfunction

    always_comb begin
        req_in                 = '0;
        req_in.adr[PLEN-1:0]   = biu_adri_i;
        req_in.size            = biu_size_i;
        req_in.btype           = biu_type_i;
        req_in.prot            = biu_prot_i;
        req_in.lock            = biu_lock_i;
        req_in.we              = biu_we_i;
    end

    // An incoming strobe counts as the queue head when the FIFO is empty, so a
    // request reaches the bus the cycle after it is accepted.
    assign biu_stb_ack_o = biu_stb_i & ~full;
    assign have_req      = ~empty | biu_stb_i;
    assign head          = empty ? req_in : fifo_q;
    assign take          = HREADY & have_req &
                           ((state == ST_IDLE) | ((state == ST_BURST) & (beat_cnt == '0)));
    assign fifo_pop      = take & ~empty;
    assign fifo_push     = biu_stb_ack_o & ~(take & empty);

    riscv_biu_reqfifo #(.DEPTH(QDEPTH)) u_reqfifo (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .push    (fifo_push),
        .d       (req_in),
        .pop     (fifo_pop),
        .q       (fifo_q),
        .full    (full),
        .empty   (empty)
    );

    assign nxt      = next_addr(HADDR, HBURST);
    assign split    = ((HBURST == HBURST_INCR4) | (HBURST == HBURST_INCR8) | (HBURST == HBURST_INCR16))
                    & (nxt[9:0] == '0);
    assign addr_vld = (HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            beat_cnt  <= '0;
            HSEL      <= 1'b0;
            HADDR     <= '0;
            HWRITE    <= 1'b0;
            HSIZE     <= '0;
            HBURST    <= '0;
            HPROT     <= HPROT_DATA | HPROT_PRIVILEGED | HPROT_NON_BUFFERABLE | HPROT_NON_CACHEABLE;
            HTRANS    <= HTRANS_IDLE;
            HMASTLOCK <= 1'b0;
        end else if (HRESP && !HREADY) begin
            state    <= ST_ERR;
            HTRANS   <= HTRANS_IDLE;
            HSEL     <= 1'b0;
            beat_cnt <= '0;
        end else if (HREADY) begin
            if (take) begin
                state     <= ST_BURST;
                HSEL      <= 1'b1;
                HTRANS    <= HTRANS_NONSEQ;
                HADDR     <= head.adr[PLEN-1:0];
                HWRITE    <= head.we;
                HSIZE     <= head.size;
                HBURST    <= head.btype;
                HPROT     <= biu_prot2hprot(head.prot);
                HMASTLOCK <= head.lock;
                beat_cnt  <= burst_beats(head.btype);
            end else begin
                unique case (state)
                    ST_BURST: begin
                        if (beat_cnt != '0) begin
                            HADDR    <= nxt;
                            beat_cnt <= beat_cnt - 1'b1;
                            if (split) begin
                                HTRANS <= HTRANS_NONSEQ;
                                HBURST <= HBURST_INCR;
                            end else begin
                                HTRANS <= HTRANS_SEQ;
                            end
                        end else begin
                            state     <= ST_IDLE;
                            HTRANS    <= HTRANS_IDLE;
                            HSEL      <= 1'b0;
                            HMASTLOCK <= biu_lock_i;
                        end
                    end
                    ST_ERR:  state <= ST_IDLE;
                    default: HMASTLOCK <= biu_lock_i;
                endcase
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            data_vld   <= 1'b0;
            d_dly      <= '0;
            HWDATA     <= '0;
            biu_adro_o <= '0;
        end else if (HREADY) begin
            data_vld   <= addr_vld;
            d_dly      <= biu_d_i;
            HWDATA     <= d_dly;
            biu_adro_o <= HADDR;
        end
    end

    assign biu_q_o     = HRDATA;
    assign biu_d_ack_o = HREADY & addr_vld;
    assign biu_ack_o   = HREADY & data_vld & ~HRESP;
    assign biu_err_o   = HREADY & data_vld & HRESP;
endmodule

// File: tb/tb_riscv_biu2ahb_q.sv
// Bench for riscv_biu2ahb_q: address-phase scoreboard plus directed checks
// on handshake timing, bursts, error abort and asynchronous reset.
module tb_riscv_biu2ahb_q;
    import riscv_mpsoc_pkg::*;

    localparam int XLEN = 64;
    localparam int PLEN = 64;
    localparam logic [63:0] RD_PATTERN = 64'h0123_4567_89AB_CDEF;

    logic            HCLK = 1'b0;
    logic            HRESETn;
    logic            HSEL, HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [PLEN-1:0] HADDR;
    logic [XLEN-1:0] HWDATA, HRDATA;
    logic [2:0]      HSIZE, HBURST;
    logic [3:0]      HPROT;
    logic [1:0]      HTRANS;
    logic            biu_stb_i, biu_stb_ack_o, biu_d_ack_o, biu_lock_i, biu_we_i;
    logic [PLEN-1:0] biu_adri_i, biu_adro_o;
    logic [2:0]      biu_size_i, biu_type_i, biu_prot_i;
    logic [XLEN-1:0] biu_d_i, biu_q_o;
    logic            biu_ack_o, biu_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [63:0] addr;
        logic [1:0]  trans;
        logic [2:0]  burst;
        logic        we;
    } beat_t;
    beat_t exp_q[$];

    always #5 HCLK = ~HCLK;
    assign HRDATA = RD_PATTERN;

    riscv_biu2ahb_q #(.XLEN(XLEN), .PLEN(PLEN), .QDEPTH(2)) dut (
        .HRESETn(HRESETn), .HCLK(HCLK), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HRESP(HRESP),
        .biu_stb_i(biu_stb_i), .biu_stb_ack_o(biu_stb_ack_o), .biu_d_ack_o(biu_d_ack_o),
        .biu_adri_i(biu_adri_i), .biu_adro_o(biu_adro_o), .biu_size_i(biu_size_i),
        .biu_type_i(biu_type_i), .biu_prot_i(biu_prot_i), .biu_lock_i(biu_lock_i),
        .biu_we_i(biu_we_i), .biu_d_i(biu_d_i), .biu_q_o(biu_q_o),
        .biu_ack_o(biu_ack_o), .biu_err_o(biu_err_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic push_beat(input logic [63:0] a, input logic [1:0] t, input logic [2:0] b, input logic we);
        beat_t e;
        e.addr = a; e.trans = t; e.burst = b; e.we = we;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [63:0] a, input logic [2:0] bt, input logic we);
        biu_stb_i  = 1'b1;
        biu_adri_i = a;
        biu_type_i = bt;
        biu_we_i   = we;
        biu_size_i = HSIZE_DWORD;
        biu_prot_i = PROT_DATA | PROT_PRIVILEGED;
        biu_lock_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge HCLK);
        check(tag, exp_q.size(), 0);
        step();
        step();
    endtask

    // every accepted address phase must match the next expected beat
    always @(negedge HCLK) begin
        if (HRESETn && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", exp_q.size(), 1);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("beat_addr",  HADDR,  e.addr);
                check("beat_trans", HTRANS, e.trans);
                check("beat_burst", HBURST, e.burst);
                check("beat_write", HWRITE, e.we);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        HRESETn = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
        biu_stb_i = 1'b0; biu_adri_i = '0; biu_type_i = '0; biu_we_i = 1'b0;
        biu_size_i = '0; biu_prot_i = '0; biu_lock_i = 1'b0; biu_d_i = '0;

        repeat (2) @(negedge HCLK);
        check("rst_hsel",   HSEL, 0);
        check("rst_haddr",  HADDR, 0);
        check("rst_hwrite", HWRITE, 0);
        check("rst_hsize",  HSIZE, 0);
        check("rst_hburst", HBURST, 0);
        check("rst_hprot",  HPROT, 4'b0011);
        check("rst_htrans", HTRANS, HTRANS_IDLE);
        check("rst_lock",   HMASTLOCK, 0);
        check("rst_hwdata", HWDATA, 0);
        check("rst_adro",   biu_adro_o, 0);
        check("rst_ack",    biu_ack_o, 0);
        check("rst_err",    biu_err_o, 0);
        step();
        HRESETn = 1'b1;
        step();

        // lock follows biu_lock_i while idle
        biu_lock_i = 1'b1;
        step();
        biu_lock_i = 1'b0;
        @(negedge HCLK) check("lock_idle_hi", HMASTLOCK, 1);
        step();
        @(negedge HCLK) check("lock_idle_lo", HMASTLOCK, 0);
        step();

        // single read: NONSEQ next cycle, ack two cycles after strobe
        push_beat(64'h100, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
        drive(64'h100, BIU_SINGLE, 1'b0);
        @(negedge HCLK) check("rd_stb_ack", biu_stb_ack_o, 1);
        step();
        biu_stb_i = 1'b0;
        @(negedge HCLK) check("rd_ack_early", biu_ack_o, 0);
        step();
        @(negedge HCLK);
        check("rd_ack",  biu_ack_o, 1);
        check("rd_q",    biu_q_o, RD_PATTERN);
        check("rd_adro", biu_adro_o, 64'h100);
        step();

        // single write: data presented with the strobe reaches HWDATA in the data phase
        push_beat(64'h180, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
        drive(64'h180, BIU_SINGLE, 1'b1);
        biu_d_i = 64'hCAFE_F00D_1234_5678;
        step();
        biu_stb_i = 1'b0;
        biu_d_i   = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        @(negedge HCLK);
        check("wr_hwdata", HWDATA, 64'hCAFE_F00D_1234_5678);
        check("wr_ack",    biu_ack_o, 1);
        step();

        // three writes with the slave stalled: queue fills, then drains back-to-back
        push_beat(64'h200, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
        push_beat(64'h208, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
        push_beat(64'h210, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
        HREADY = 1'b0;
        drive(64'h200, BIU_SINGLE, 1'b1);
        @(negedge HCLK) check("q_ack0", biu_stb_ack_o, 1);
        step();
        drive(64'h208, BIU_SINGLE, 1'b1);
        @(negedge HCLK) check("q_ack1", biu_stb_ack_o, 1);
        step();
        drive(64'h210, BIU_SINGLE, 1'b1);
        @(negedge HCLK) check("q_full_ack", biu_stb_ack_o, 0);
        step();
        HREADY = 1'b1;
        @(negedge HCLK) check("q_full_hold", biu_stb_ack_o, 0);
        step();
        @(negedge HCLK);
        check("q_ack2", biu_stb_ack_o, 1);
        check("q_ns0", HTRANS, HTRANS_NONSEQ);
        step();
        biu_stb_i = 1'b0;
        @(negedge HCLK) check("q_ns1", HTRANS, HTRANS_NONSEQ);
        step();
        @(negedge HCLK) check("q_ns2", HTRANS, HTRANS_NONSEQ);
        step();
        @(negedge HCLK) check("q_idle", HTRANS, HTRANS_IDLE);
        drain("q_drain");

        // INCR8 across the 1 KB boundary
        push_beat(64'h3E0, HTRANS_NONSEQ, HBURST_INCR8, 1'b0);
        push_beat(64'h3E8, HTRANS_SEQ,    HBURST_INCR8, 1'b0);
        push_beat(64'h3F0, HTRANS_SEQ,    HBURST_INCR8, 1'b0);
        push_beat(64'h3F8, HTRANS_SEQ,    HBURST_INCR8, 1'b0);
        push_beat(64'h400, HTRANS_NONSEQ, HBURST_INCR,  1'b0);
        push_beat(64'h408, HTRANS_SEQ,    HBURST_INCR,  1'b0);
        push_beat(64'h410, HTRANS_SEQ,    HBURST_INCR,  1'b0);
        push_beat(64'h418, HTRANS_SEQ,    HBURST_INCR,  1'b0);
        drive(64'h3E0, BIU_INCR8, 1'b0);
        @(negedge HCLK) check("i8_stb_ack", biu_stb_ack_o, 1);
        step();
        biu_stb_i = 1'b0;
        drain("i8_drain");

        // WRAP4 wraps within its 32-byte window
        push_beat(64'h118, HTRANS_NONSEQ, HBURST_WRAP4, 1'b0);
        push_beat(64'h100, HTRANS_SEQ,    HBURST_WRAP4, 1'b0);
        push_beat(64'h108, HTRANS_SEQ,    HBURST_WRAP4, 1'b0);
        push_beat(64'h110, HTRANS_SEQ,    HBURST_WRAP4, 1'b0);
        drive(64'h118, BIU_WRAP4, 1'b0);
        step();
        biu_stb_i = 1'b0;
        drain("w4_drain");

        // ERROR on beat 2 of INCR4, queued SINGLE issues afterwards
        push_beat(64'h500, HTRANS_NONSEQ, HBURST_INCR4,  1'b0);
        push_beat(64'h508, HTRANS_SEQ,    HBURST_INCR4,  1'b0);
        push_beat(64'h600, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
        drive(64'h500, BIU_INCR4, 1'b0);
        step();
        drive(64'h600, BIU_SINGLE, 1'b0);
        @(negedge HCLK) check("er_q_ack", biu_stb_ack_o, 1);
        step();
        biu_stb_i = 1'b0;
        @(negedge HCLK) check("er_beat1_ack", biu_ack_o, 1);
        step();
        HREADY = 1'b0; HRESP = 1'b1;
        @(negedge HCLK) check("er_first_cycle", biu_err_o, 0);
        step();
        HREADY = 1'b1;
        @(negedge HCLK);
        check("er_pulse",  biu_err_o, 1);
        check("er_htrans", HTRANS, HTRANS_IDLE);
        check("er_hsel",   HSEL, 0);
        step();
        HRESP = 1'b0;
        @(negedge HCLK);
        check("er_once",  biu_err_o, 0);
        check("er_idle2", HTRANS, HTRANS_IDLE);
        drain("er_drain");

        // asynchronous reset in the middle of an INCR16 with a request queued
        push_beat(64'h800, HTRANS_NONSEQ, HBURST_INCR16, 1'b0);
        push_beat(64'h808, HTRANS_SEQ,    HBURST_INCR16, 1'b0);
        drive(64'h800, BIU_INCR16, 1'b0);
        step();
        drive(64'h900, BIU_SINGLE, 1'b0);
        step();
        biu_stb_i = 1'b0;
        step();
        #2 HRESETn = 1'b0;
        @(negedge HCLK);
        check("ar_htrans", HTRANS, HTRANS_IDLE);
        check("ar_hsel",   HSEL, 0);
        check("ar_haddr",  HADDR, 0);
        check("ar_hburst", HBURST, 0);
        step();
        HRESETn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK) check("ar_queue_empty", HTRANS, HTRANS_IDLE);
            step();
        end

        check("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/riscv_biu2ahb_q.md
# riscv_biu2ahb_q

Queued, parametrised BIU-to-AHB-Lite master bridge for the MPSoC-RISCV core. It accepts core BIU requests into a request queue of configurable depth and issues them back-to-back on AHB without idle cycles between transfers. It splits incrementing bursts at 1 KB boundaries and aborts bursts cleanly on error. It sits between the core's instruction or data BIU port and the AHB4-Lite interconnect.

## Interface
- XLEN, 64, data width; legal values 32 or 64.
- PLEN, 64, address width; minimum 12.
- QDEPTH, 2, request-queue entries; power of 2, ≥1.
- HCLK  in  1  bus clock; all logic is rising-edge.
- HRESETn  in  1  reset HRESETn, asynchronous, active-low; clock HCLK.
- HSEL, HADDR[PLEN], HWDATA[XLEN], HWRITE, HSIZE[3], HBURST[3], HPROT[4], HTRANS[2], HMASTLOCK  out  AHB master outputs.
- HRDATA[XLEN], HREADY, HRESP  in  AHB master inputs.
- biu_stb_i  in  1  request strobe.
- biu_stb_ack_o  out  1  request accepted this cycle.
- biu_adri_i  in  PLEN  request address.
- biu_size_i, biu_type_i, biu_prot_i  in  3 each  request size, burst type and protection.
- biu_lock_i, biu_we_i  in  1 each  lock and write request.
- biu_d_ack_o  out  1  present the next write beat on biu_d_i.
- biu_d_i  in  XLEN  write data.
- biu_q_o  out  XLEN  read data, equal to HRDATA.
- biu_adro_o  out  PLEN  address of the completing beat.
- biu_ack_o  out  1  beat completed OK.
- biu_err_o  out  1  beat completed with error.

## Operation
- Request queue: biu_stb_ack_o = biu_stb_i & !full. An entry holds {adr, size, type, prot, lock, we}. Push and pop in the same cycle are legal when full.
- Address FSM has three states: IDLE, BURST, ERR.
- IDLE → BURST: when HREADY and the queue is non-empty.
  - Pop the entry and drive HTRANS=NONSEQ with HSEL=1.
  - Drive HADDR, HWRITE, HSIZE, HBURST and HPROT from the entry.
  - Load beat_cnt from the burst type: SINGLE/INCR=0, x4=3, x8=7, x16=15.
- BURST, each HREADY with beat_cnt≠0: HTRANS=SEQ, HADDR=next address, beat_cnt-1.
  - Next address = (addr+XLEN/8), aligned; wrap types keep the upper bits.
- BURST, each HREADY with beat_cnt=0:
  - Queue non-empty: issue the next NONSEQ immediately, with no IDLE cycle.
  - Queue empty: go to IDLE; HTRANS=IDLE, HSEL=0.
- 1 KB split: for INCR4/8/16, if the next address has [9:0]=0, drive HTRANS=NONSEQ and HBURST=INCR for that beat and all remaining beats. beat_cnt is unchanged. WRAP bursts never split.
- Error: HRESP=1 with HREADY=0 (first error cycle).
  - Drive HTRANS=IDLE and HSEL=0; clear beat_cnt; enter ERR.
  - ERR → IDLE on the following HREADY.
  - Queued entries are kept and issue afterwards.
- HMASTLOCK follows the entry's lock bit and holds through the burst. In IDLE it follows biu_lock_i.
- Data phase:
  - data_vld shifts from addr_vld on HREADY.
  - HWDATA and biu_adro_o register on HREADY.
  - Write data is taken from a one-deep delay of biu_d_i, registered on HREADY.
- Handshake outputs (combinational):
  - biu_d_ack_o = HREADY & addr_vld.
  - biu_ack_o = HREADY & data_vld & !HRESP.
  - biu_err_o = HREADY & data_vld & HRESP (second error cycle).

## Timing
- Reset values of outputs:
  - HSEL=0, HADDR=0, HWRITE=0, HSIZE=0, HBURST=0.
  - HPROT = DATA|PRIVILEGED|NON_BUFFERABLE|NON_CACHEABLE.
  - HTRANS=IDLE, HMASTLOCK=0, HWDATA=0, biu_adro_o=0.
  - Acknowledge and error outputs are 0 because data_vld=0.
- Latency: strobe accepted in cycle N with the queue empty and the FSM idle → NONSEQ in cycle N+1 → first biu_ack_o in cycle N+2 with zero wait states.
- Back-to-back requests: sustained one beat per cycle.
- HREADY low: every register holds.
- Reset asserted mid-burst: all state clears immediately, the queue empties, and HTRANS=IDLE asynchronously.

## Structure
- Shared constants live in riscv_mpsoc_pkg: HTRANS_*, HBURST_*, HSIZE_*, HPROT_*, HRESP_*, the BIU burst types and PROT_*.
- Add a packed biu_req_t struct to the package.
- One sub-module: riscv_biu_reqfifo, a parametrised synchronous FIFO of biu_req_t with full/empty flags, reset by HRESETn.

## Test plan
- Single 64-bit read at 0x100, no wait states → NONSEQ/SINGLE at 0x100; biu_ack_o two cycles after the strobe; biu_q_o = HRDATA.
- Three SINGLE writes strobed back-to-back with QDEPTH=2 → biu_stb_ack_o low exactly while the queue is full; three consecutive NONSEQ beats with no IDLE gap.
- INCR8 starting at 0x3E0 (XLEN=64) → beats 0x3E0, 0x3E8, 0x3F0, 0x3F8, then NONSEQ/INCR at 0x400, followed by three SEQ beats.
- WRAP4 at 0x118 → addresses 0x118, 0x100, 0x108, 0x110; HBURST=WRAP4 throughout.
- Error on beat 2 of an INCR4 → HTRANS=IDLE in the first error cycle; biu_err_o pulses one cycle; no further SEQ beats; the queued request then issues as NONSEQ.
- HRESETn asserted mid-INCR16 → all outputs return to reset values immediately; the queue is empty after release.
